// File: rtl/dma_priority_encoder.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// dma_priority_encoder
//
// Purpose:
//   DREQ arbiter for a 4-channel 8237A-style DMA controller. Raw channel
//   requests are qualified by sense polarity and mask. One channel is picked
//   by fixed or rotating priority, then Hrq is raised towards the CPU. Once
//   Hlda is granted, the DACK of the winning channel is driven. The
//   timing/control FSM downstream consumes ReqID/ValidReqID.
//
// Configuration macro:
//   PE_ROTATING_EN
//     - defined:   RotatingPriority selects fixed (0) or rotating (1) priority.
//     - undefined: fixed priority only. RotatingPriority is ignored and no
//                  rotation pointer is built.
//
// Ports:
//   Clock            in   system clock, all logic on posedge
//   Reset            in   synchronous, active-high reset
//   Dreq[3:0]        in   raw channel requests (polarity per SenseDreq)
//   Hlda             in   hold acknowledge from CPU
//   RotatingPriority in   0 = fixed priority, 1 = rotating priority
//   SenseDreq        in   0 = Dreq active-high, 1 = Dreq active-low
//   SenseDack        in   0 = Dack active-low, 1 = Dack active-high
//   DmaDisable       in   1 = no new arbitration / Hrq
//   Mask[3:0]        in   1 = channel masked
//   PendingReq[3:0]  out  registered qualified requests (active-high)
//   Hrq              out  hold request to CPU
//   Dack[3:0]        out  channel acknowledges (polarity per SenseDack)
//   ValidReqID       out  ReqID holds a valid winner
//   ReqID[1:0]       out  index of the winning channel
//   o_dbg_state[1:0] out  current arbiter FSM state (IDLE=0, REQ=1, GRANT=2)
//
// Handshake:
//   Hrq/ValidReqID rise together one cycle after a qualified request is seen
//   in IDLE. Hlda is a level: while it is sampled high in REQ, the arbiter
//   moves to GRANT and drives Dack[ReqID]. Service ends on the cycle after
//   Hlda falls or after the serviced request is withdrawn or masked.
// ----------------------------------------------------------------------------
module dma_priority_encoder #(
    parameter int NUM_CH   = 4,
    parameter int REQ_ID_W = 2
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [NUM_CH-1:0]   Dreq,
    input  logic                Hlda,
    input  logic                RotatingPriority,
    input  logic                SenseDreq,
    input  logic                SenseDack,
    input  logic                DmaDisable,
    input  logic [NUM_CH-1:0]   Mask,
    output logic [NUM_CH-1:0]   PendingReq,
    output logic                Hrq,
    output logic [NUM_CH-1:0]   Dack,
    output logic                ValidReqID,
    output logic [REQ_ID_W-1:0] ReqID,
    output logic [1:0]          o_dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_GRANT = 2'd2;

    localparam logic [NUM_CH-1:0] ONE_CH = {{(NUM_CH-1){1'b0}}, 1'b1};

    logic [1:0]          r_state;
    logic [REQ_ID_W-1:0] r_req_id;
    logic                r_valid;
    logic                r_hrq;
    logic [NUM_CH-1:0]   r_dack_act;
    logic [NUM_CH-1:0]   r_pending;
    // Dreq sense captured when service starts, so a mid-service sense change
    // cannot flip the serviced request and end the transfer early.
    logic                r_sense_dreq_svc;

    logic [NUM_CH-1:0]   w_eff_req;
    logic [NUM_CH-1:0]   w_eff_svc;
    logic                w_svc_req;
    logic [REQ_ID_W-1:0] w_fixed_id;
    logic [REQ_ID_W-1:0] w_winner;
    logic [NUM_CH-1:0]   w_dack_act;
    logic                w_grant_exit;

    assign w_eff_req = (SenseDreq ? ~Dreq : Dreq) & ~Mask;
    assign w_eff_svc = (r_sense_dreq_svc ? ~Dreq : Dreq) & ~Mask;
    assign w_svc_req = w_eff_svc[r_req_id];

    assign w_grant_exit = (r_state == ST_GRANT) && (!Hlda || !w_svc_req);

    // Fixed priority: scan from the top down so the lowest index wins.
    always_comb begin
        w_fixed_id = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_eff_req[i]) begin
                w_fixed_id = REQ_ID_W'(i);
            end
        end
    end

`ifdef PE_ROTATING_EN
    logic [REQ_ID_W-1:0] r_lowest;
    logic [REQ_ID_W-1:0] w_rot_id;
    logic                w_rot_found;

    // Search starts one past the last-serviced channel and wraps. The final
    // step (k = NUM_CH) truncates back onto r_lowest itself.
    always_comb begin
        logic [REQ_ID_W-1:0] idx;
        w_rot_id    = '0;
        w_rot_found = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = r_lowest + REQ_ID_W'(k);
            if (!w_rot_found && w_eff_req[idx]) begin
                w_rot_id    = idx;
                w_rot_found = 1'b1;
            end
        end
    end

    assign w_winner = RotatingPriority ? w_rot_id : w_fixed_id;

    // Only a completed GRANT counts as a service. A request dropped while
    // still in REQ leaves the rotation untouched.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_lowest <= REQ_ID_W'(NUM_CH - 1);
        end else if (w_grant_exit) begin
            r_lowest <= r_req_id;
        end
    end
`else
    logic w_unused_rot;
    assign w_unused_rot = RotatingPriority;
    assign w_winner     = w_fixed_id;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state          <= ST_IDLE;
            r_req_id         <= '0;
            r_valid          <= 1'b0;
            r_hrq            <= 1'b0;
            r_dack_act       <= '0;
            r_pending        <= '0;
            r_sense_dreq_svc <= 1'b0;
        end else begin
            r_pending <= w_eff_req;
            case (r_state)
                ST_IDLE: begin
                    r_sense_dreq_svc <= SenseDreq;
                    if (|w_eff_req && !DmaDisable) begin
                        r_req_id <= w_winner;
                        r_valid  <= 1'b1;
                        r_hrq    <= 1'b1;
                        r_state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A request withdrawn before Hlda is abandoned. The
                    // arbiter never grants a channel that is no longer asking.
                    if (!w_svc_req) begin
                        r_valid <= 1'b0;
                        r_hrq   <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (Hlda) begin
                        r_dack_act <= ONE_CH << r_req_id;
                        r_state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_grant_exit) begin
                        r_dack_act <= '0;
                        r_valid    <= 1'b0;
                        r_hrq      <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_dack_act <= '0;
                    r_valid    <= 1'b0;
                    r_hrq      <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    // The registered Dack is also gated by the live mask. Masking the active
    // channel removes its Dack at once, and service ends on the next edge.
    assign w_dack_act = r_dack_act & ~Mask;

    assign PendingReq  = r_pending;
    assign Hrq         = r_hrq;
    assign ValidReqID  = r_valid;
    assign ReqID       = r_req_id;
    assign Dack        = SenseDack ? w_dack_act : ~w_dack_act;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dma_priority_encoder.sv
`timescale 1ns/1ps
module tb_dma_priority_encoder;

    logic       Clock;
    logic       Reset;
    logic [3:0] Dreq;
    logic       Hlda;
    logic       RotatingPriority;
    logic       SenseDreq;
    logic       SenseDack;
    logic       DmaDisable;
    logic [3:0] Mask;
    logic [3:0] PendingReq;
    logic       Hrq;
    logic [3:0] Dack;
    logic       ValidReqID;
    logic [1:0] ReqID;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected {ValidReqID, Hrq, ReqID, Dack}, pushed with each stimulus step
    logic [7:0] exp_q[$];
    // Expected PendingReq, pushed when random stimulus is driven
    logic [3:0] pend_q[$];

    dma_priority_encoder #(.NUM_CH(4), .REQ_ID_W(2)) dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .Dreq             (Dreq),
        .Hlda             (Hlda),
        .RotatingPriority (RotatingPriority),
        .SenseDreq        (SenseDreq),
        .SenseDack        (SenseDack),
        .DmaDisable       (DmaDisable),
        .Mask             (Mask),
        .PendingReq       (PendingReq),
        .Hrq              (Hrq),
        .Dack             (Dack),
        .ValidReqID       (ValidReqID),
        .ReqID            (ReqID),
        .o_dbg_state      (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] eff_of(input logic s, input logic [3:0] d, input logic [3:0] m);
        return (s ? ~d : d) & ~m;
    endfunction

    function automatic logic [3:0] dack_pat(input logic sense, input logic act, input logic [1:0] id);
        logic [3:0] one;
        logic [3:0] v;
        one = 4'b0001;
        v   = act ? (one << id) : 4'b0000;
        return sense ? v : ~v;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic expect_out(input logic v, input logic h, input logic [1:0] id, input logic [3:0] d);
        exp_q.push_back({v, h, id, d});
    endtask

    task automatic compare_out(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, ValidReqID, e[7]);
            check({tag, "_hrq"}, Hrq, e[6]);
            if (e[7]) check({tag, "_reqid"}, ReqID, e[5:4]);
            check({tag, "_dack"}, Dack, e[3:0]);
        end
    endtask

    task automatic step(input string tag, input logic v, input logic h, input logic [1:0] id, input logic [3:0] d);
        expect_out(v, h, id, d);
        tick();
        compare_out(tag);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    // Three back-to-back services with Dreq=0011 held; the expected winners
    // depend on whether rotation is both built and selected.
    task automatic run_services(input logic rot);
        logic [1:0] id;
        logic       rot_built;
`ifdef PE_ROTATING_EN
        rot_built = 1'b1;
`else
        rot_built = 1'b0;
`endif
        do_reset();
        RotatingPriority = rot;
        Dreq = 4'b0011;
        Mask = 4'b0000;
        for (int s = 0; s < 3; s++) begin
            id = (rot && rot_built && s == 1) ? 2'd1 : 2'd0;
            Hlda = 1'b0;
            step($sformatf("svc%0d_r%0d_arb", s, rot), 1, 1, id, 4'hF);
            Hlda = 1'b1;
            step($sformatf("svc%0d_r%0d_grant", s, rot), 1, 1, id, dack_pat(1'b0, 1'b1, id));
            Hlda = 1'b0;
            step($sformatf("svc%0d_r%0d_exit", s, rot), 0, 0, 2'd0, 4'hF);
        end
        Dreq = 4'b0000;
        RotatingPriority = 1'b0;
        step("svc_done", 0, 0, 2'd0, 4'hF);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] act;
        logic [3:0] e_now;
        logic [3:0] p;
        int         lat;
        int         hold;

        Reset = 1'b1;
        Dreq = 4'b0; Hlda = 1'b0; RotatingPriority = 1'b0;
        SenseDreq = 1'b0; SenseDack = 1'b0; DmaDisable = 1'b0; Mask = 4'b0;
        tick();
        tick();
        check("rst_pending", PendingReq, 4'h0);
        check("rst_hrq", Hrq, 1'b0);
        check("rst_valid", ValidReqID, 1'b0);
        check("rst_reqid", ReqID, 2'd0);
        check("rst_dack_lo", Dack, 4'hF);
        SenseDack = 1'b1;
        #1;
        check("rst_dack_hi", Dack, 4'h0);
        SenseDack = 1'b0;
        Reset = 1'b0;
        tick();

        // masked channel never wins nor gets Dack
        Mask = 4'b0100; Dreq = 4'b1100;
        step("t1_arb", 1, 1, 2'd3, 4'hF);
        Hlda = 1'b1;
        step("t1_grant", 1, 1, 2'd3, 4'b0111);
        step("t1_hold", 1, 1, 2'd3, 4'b0111);
        check("t1_ch2_never", Dack[2], 1'b1);
        Dreq = 4'b0000;
        step("t1_exit", 0, 0, 2'd0, 4'hF);
        // no requests while Hlda high
        step("t3_idle", 0, 0, 2'd0, 4'hF);
        check("t3_pending", PendingReq, 4'h0);

        // fixed priority, ReqID stable during grant
        Hlda = 1'b0; Mask = 4'b0000; Dreq = 4'b1100;
        step("t2_arb", 1, 1, 2'd2, 4'hF);
        Hlda = 1'b1;
        for (int i = 0; i < 3; i++) step("t2_grant", 1, 1, 2'd2, 4'b1011);
        check("t2_pending", PendingReq, 4'b1100);
        Hlda = 1'b0; Dreq = 4'b0000;
        step("t2_exit", 0, 0, 2'd0, 4'hF);

        // masking the active channel mid-grant
        Dreq = 4'b0001;
        step("mk_arb", 1, 1, 2'd0, 4'hF);
        Hlda = 1'b1;
        step("mk_grant", 1, 1, 2'd0, 4'b1110);
        Mask = 4'b0001;
        #1;
        check("mk_dack_comb", Dack, 4'hF);
        step("mk_exit", 0, 0, 2'd0, 4'hF);
        Hlda = 1'b0; Dreq = 4'b0000; Mask = 4'b0000;
        step("mk_idle", 0, 0, 2'd0, 4'hF);

        // DmaDisable blocks new arbitration only
        DmaDisable = 1'b1; Dreq = 4'b0010;
        step("dis_block0", 0, 0, 2'd0, 4'hF);
        step("dis_block1", 0, 0, 2'd0, 4'hF);
        DmaDisable = 1'b0;
        step("dis_arb", 1, 1, 2'd1, 4'hF);
        DmaDisable = 1'b1; Hlda = 1'b1;
        step("dis_grant", 1, 1, 2'd1, 4'b1101);
        Hlda = 1'b0;
        step("dis_exit", 0, 0, 2'd0, 4'hF);
        step("dis_noarb", 0, 0, 2'd0, 4'hF);
        DmaDisable = 1'b0; Dreq = 4'b0000;
        step("dis_idle", 0, 0, 2'd0, 4'hF);

        // sense polarities
        SenseDack = 1'b1; Dreq = 4'b0100;
        step("t4_arb", 1, 1, 2'd2, 4'h0);
        Hlda = 1'b1;
        step("t4_grant", 1, 1, 2'd2, 4'b0100);
        Hlda = 1'b0; Dreq = 4'b0000;
        step("t4_exit", 0, 0, 2'd0, 4'h0);
        SenseDreq = 1'b1; Dreq = 4'b1110;
        step("t4_sdreq_arb", 1, 1, 2'd0, 4'h0);
        Dreq = 4'b1111;
        step("t4_sdreq_drop", 0, 0, 2'd0, 4'h0);
        SenseDreq = 1'b0; SenseDack = 1'b0; Dreq = 4'b0000;
        step("t4_idle", 0, 0, 2'd0, 4'hF);

        // reset in the middle of a grant
        Dreq = 4'b1000;
        step("rm_arb", 1, 1, 2'd3, 4'hF);
        Hlda = 1'b1;
        step("rm_grant", 1, 1, 2'd3, 4'b0111);
        Reset = 1'b1;
        step("rm_reset", 0, 0, 2'd0, 4'hF);
        check("rm_reqid", ReqID, 2'd0);
        check("rm_pending", PendingReq, 4'h0);
        Reset = 1'b0; Hlda = 1'b0; Dreq = 4'b0000;
        tick();

        // fixed vs rotating priority
        run_services(1'b0);
        run_services(1'b1);

        // random mask / request / grant traffic
        lat = 0;
        for (int it = 0; it < 150; it++) begin
            Mask       = 4'($urandom_range(0, 15));
            Dreq       = 4'($urandom_range(0, 15));
            DmaDisable = ($urandom_range(0, 7) == 0);
            SenseDack  = 1'($urandom_range(0, 1));
            hold       = $urandom_range(1, 4);
            for (int c = 0; c < hold; c++) begin
                Hlda = 1'($urandom_range(0, 1));
                e_now = eff_of(SenseDreq, Dreq, Mask);
                pend_q.push_back(e_now);
                tick();
                p = pend_q.pop_front();
                check("rnd_pending", PendingReq, p);
                act = SenseDack ? Dack : ~Dack;
                check("rnd_dack_onehot0", $onehot0(act), 1'b1);
                check("rnd_dack_masked", act & Mask, 4'h0);
                if (e_now != 4'h0 && !DmaDisable && !(ValidReqID && Hrq)) lat++;
                else lat = 0;
                check("rnd_latency", (lat <= 10), 1'b1);
            end
        end
        Dreq = 4'b0; Mask = 4'b0; Hlda = 1'b0; DmaDisable = 1'b0; SenseDack = 1'b0;
        tick();
        tick();
        check("final_idle_valid", ValidReqID, 1'b0);
        check("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
